// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: memory opcodes, FSM states, access sizes.
package mem_pkg;

    localparam logic [4:0] OP_LB  = 5'b10000;
    localparam logic [4:0] OP_LH  = 5'b10001;
    localparam logic [4:0] OP_LW  = 5'b10010;
    localparam logic [4:0] OP_LBU = 5'b10100;
    localparam logic [4:0] OP_LHU = 5'b10101;
    localparam logic [4:0] OP_SB  = 5'b11000;
    localparam logic [4:0] OP_SH  = 5'b11001;
    localparam logic [4:0] OP_SW  = 5'b11010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
            default:             is_mem_op = 1'b0;
        endcase
    endfunction

    // Low two opcode bits encode the access size for every memory op.
    function automatic size_t op_size(input logic [4:0] op);
        case (op[1:0])
            2'b00:   op_size = BYTE;
            2'b01:   op_size = HALF;
            default: op_size = WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [31:0] shifted;

    always_comb begin
        be      = 4'b1111;
        wdata   = sdata;
        shifted = rdata;
        ldata   = rdata;
        case (size)
            BYTE: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{sdata[7:0]}};
                shifted = rdata >> {addr_lo, 3'b000};
                ldata   = uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                // Only addr[1] selects the half; addr[0] is ignored here.
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{sdata[15:0]}};
                shifted = addr_lo[1] ? {16'd0, rdata[31:16]} : rdata;
                ldata   = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be    = 4'b1111;
                wdata = sdata;
                ldata = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: req/gnt/rvalid handshake to data memory, upstream stall, registered writeback.
// Optional feature: MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of masking them.
//
// state | meaning
// IDLE  | pass non-memory results through; latch a new memory op
// REQ   | request held stable until mem_gnt_i
// WAIT  | load granted, waiting for mem_rvalid_i
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ALUop_i,
    input  logic [ADDR_W-1:0] MemAddr_i,
    input  logic [DATA_W-1:0] StoreData_i,
    input  logic [DATA_W-1:0] WriteData_i,
    input  logic [4:0]        WriteDataNum_i,
    input  logic              WriteReg_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              WriteReg_o,
    output logic [4:0]        WriteDataNum_o,
    output logic [DATA_W-1:0] WriteData_o,
    output logic              misalign_o
);

    state_t            state;
    size_t             size_q;
    logic              st_q, uns_q, wreg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [4:0]        num_q;
    logic              new_mem, misaligned, drop;
    logic [3:0]        be_w;
    logic [DATA_W-1:0] wdata_w, ldata_w;

    mem_lane_align u_align (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .uns     (uns_q),
        .sdata   (sdata_q),
        .rdata   (mem_rdata_i),
        .be      (be_w),
        .wdata   (wdata_w),
        .ldata   (ldata_w)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    // The trapped op is still presented for one more cycle; that cycle consumes it.
    assign drop       = mis_q;
    assign misalign_o = mis_q;
    assign misaligned = ((op_size(ALUop_i) == HALF) && MemAddr_i[0]) ||
                        ((op_size(ALUop_i) == WORD) && (MemAddr_i[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mis_q <= 1'b0;
        else
            mis_q <= (state == IDLE) && !mis_q && new_mem && misaligned;
    end
`else
    assign drop       = 1'b0;
    assign misalign_o = 1'b0;
    assign misaligned = 1'b0;
`endif

    assign new_mem     = is_mem_op(ALUop_i);
    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = mem_req_o && st_q;
    assign mem_be_o    = mem_req_o ? be_w : 4'b0000;
    assign mem_addr_o  = mem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata_o = mem_we_o ? wdata_w : '0;

    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = new_mem && !drop;
            REQ:     stall_o = !mem_gnt_i || !st_q;
            WAIT:    stall_o = !mem_rvalid_i;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            size_q         <= BYTE;
            st_q           <= 1'b0;
            uns_q          <= 1'b0;
            wreg_q         <= 1'b0;
            addr_q         <= '0;
            sdata_q        <= '0;
            num_q          <= '0;
            WriteReg_o     <= 1'b0;
            WriteDataNum_o <= '0;
            WriteData_o    <= '0;
        end else begin
            WriteReg_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop) begin
                        state <= IDLE;
                    end else if (new_mem) begin
                        size_q  <= op_size(ALUop_i);
                        st_q    <= ALUop_i[3];
                        uns_q   <= ALUop_i[2];
                        wreg_q  <= WriteReg_i;
                        addr_q  <= MemAddr_i;
                        sdata_q <= StoreData_i;
                        num_q   <= WriteDataNum_i;
                        state   <= misaligned ? IDLE : REQ;
                    end else begin
                        WriteReg_o     <= WriteReg_i;
                        WriteDataNum_o <= WriteDataNum_i;
                        WriteData_o    <= WriteData_i;
                    end
                end
                REQ: begin
                    if (mem_gnt_i)
                        state <= st_q ? IDLE : WAIT;
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        WriteReg_o     <= wreg_q;
                        WriteDataNum_o <= num_q;
                        WriteData_o    <= ldata_w;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
